mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
// - Shares the single external memory bus between the fetch-side icache (I) and
//   the memory-stage dcache (D) port.
// - Holds one outstanding transaction at a time and locks the grant until the
//   memory responds or a watchdog expires.
// - Routes the response only to the granted master.
// - Sits between both caches and the memory bus at the top of the core.
// PARAMETERS
// - TIMEOUT      default 1024  cycles in BUSY without mem_ready before abort (>=2)
// - ADDR_W       default 32    address width
// - DATA_W       default 32    data width; strobe width is DATA_W/8
// PORTS
// - clk          in   1        core clock; all state on rising edge
// - rst_n        in   1        asynchronous, active-low reset
// - i_req        in   1        icache read request; held until i_ready
// - i_addr       in   ADDR_W   icache read address
// - i_ready      out  1        1-cycle pulse: I transaction done
// - i_rdata      out  DATA_W   read data, valid with i_ready
// - i_error      out  1        bus error/timeout, valid with i_ready
// - d_req        in   1        dcache request; held until d_ready
// - d_we         in   1        1 = write, 0 = read
// - d_addr       in   ADDR_W   dcache address
// - d_wdata      in   DATA_W   write data
// - d_wstrb      in   DATA_W/8 byte strobes
// - d_ready      out  1        1-cycle pulse: D transaction done
// - d_rdata      out  DATA_W   read data, valid with d_ready
// - d_error      out  1        bus error/timeout, valid with d_ready
// - mem_req      out  1        request to memory, held until mem_ready/abort
// - mem_we / mem_addr / mem_wdata / mem_wstrb   out   latched fields of winner
// - mem_ready    in   1        1-cycle completion pulse from memory
// - mem_rdata    in   DATA_W   memory read data
// - mem_error    in   1        memory error, valid with mem_ready
// - mem_abort    out  1        1-cycle pulse on watchdog expiry
// - busy         out  1        1 while in BUSY
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE, owner=I, timer=0.
//   All outputs 0, including mem_* fields. Any in-flight transaction is dropped
//   with no response.
// - States: IDLE, BUSY.
//   - IDLE: sample requests; on any req, latch the winner's fields into mem_*
//     regs, set owner, go BUSY. No req: stay IDLE.
//   - BUSY: mem_req=1, fields frozen.
//     - mem_ready: pulse <owner>_ready with rdata/error (registered, next
//       cycle), go IDLE.
//     - Timer reaches TIMEOUT-1 without mem_ready: pulse mem_abort, pulse
//       <owner>_ready with <owner>_error=1 and rdata=0, go IDLE.
// - Latency: req seen in cycle N -> mem_req high at N+1.
//   mem_ready at cycle M -> master ready at M+1.
//   Earliest re-arbitration at M+1, so the next mem_req is at M+2.
// - Timer: clears on entry to BUSY, increments each BUSY cycle, saturates;
//   $clog2(TIMEOUT) bits.
// - mem_ready and timeout in the same cycle: mem_ready wins, no abort.
// - A master deasserting req while granted is ignored. The transaction
//   completes and the ready pulse is still issued.
// - Non-granted master's ready/error: always 0. rdata: 0 when not pulsing.
// - A req arriving during BUSY waits; it is arbitrated in the next IDLE cycle.
// - i_* requests are always reads; mem_we=0 and mem_wstrb=0 for I grants.
// CONFIGURATION
// - MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous i_req & d_req, the master
//   NOT granted last wins; the last-grant flag resets to I, so D wins first.
// - Undefined: fixed priority, D always beats I (I may starve under D traffic).
// - A single request is granted identically in both modes.
// TESTING
// - Single I read addr 0x80000000, mem_ready after 3 cycles with rdata
//   0x00000013 -> mem_req at N+1, i_ready pulse with i_rdata 0x13; d_ready
//   stays 0.
// - D write 0x80001000 data 0xDEADBEEF strb 0xF, I req same cycle ->
//   D granted first (mem_we=1), then I; i_ready only after d_ready.
// - Both request continuously for 4 transactions -> fixed: D,D,D,D;
//   with MEM_ARB_ROUND_ROBIN_EN: D,I,D,I.
// - TIMEOUT=8, memory never responds -> mem_abort pulse after 8 BUSY cycles,
//   i_error=1 with i_ready, state IDLE.
// - mem_ready coincident with the final timeout cycle -> normal completion,
//   error=0, no mem_abort.
// - rst_n low mid-BUSY -> mem_req, busy and all ready outputs 0 immediately;
//   after release the first req is granted normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between icache (I) and dcache (D).
// One outstanding transaction; the grant is held until mem_ready or watchdog expiry.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: alternate grants on simultaneous
// requests. When it is undefined, D has fixed priority over I.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_ready,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_error,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic                  d_ready,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_error,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_error,
    output logic                  mem_abort,
    output logic                  busy
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t              state, state_nxt;
    logic                owner_d, owner_d_nxt;
    logic [TMR_W-1:0]    timer, timer_nxt;
    logic                we_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;
    logic [STRB_W-1:0]   wstrb_nxt;
    logic                i_ready_nxt, i_error_nxt, d_ready_nxt, d_error_nxt, abort_nxt;
    logic [DATA_W-1:0]   i_rdata_nxt, d_rdata_nxt;
    logic                any_req, grant_d, prefer_d, expire;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                last_d, last_d_nxt;
`endif

    // Arbitration: D wins a tie unless round-robin says I is due
`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign prefer_d = !last_d;
`else
    assign prefer_d = 1'b1;
`endif
    assign any_req  = i_req || d_req;
    assign grant_d  = d_req && (!i_req || prefer_d);
    assign expire   = (timer == TMR_W'(TIMEOUT - 1));

    assign mem_req  = (state == BUSY);
    assign busy     = (state == BUSY);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: grant on any request, release on completion or watchdog
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (mem_ready || expire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output/datapath next values: latch winner, run watchdog, route response
    always_comb begin
        owner_d_nxt = owner_d;
        timer_nxt   = timer;
        we_nxt      = mem_we;
        addr_nxt    = mem_addr;
        wdata_nxt   = mem_wdata;
        wstrb_nxt   = mem_wstrb;
        i_ready_nxt = 1'b0;
        i_rdata_nxt = '0;
        i_error_nxt = 1'b0;
        d_ready_nxt = 1'b0;
        d_rdata_nxt = '0;
        d_error_nxt = 1'b0;
        abort_nxt   = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d_nxt  = last_d;
`endif
        case (state)
            IDLE: begin
                if (any_req) begin
                    owner_d_nxt = grant_d;
                    timer_nxt   = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d_nxt  = grant_d;
`endif
                    if (grant_d) begin
                        we_nxt    = d_we;
                        addr_nxt  = d_addr;
                        wdata_nxt = d_wdata;
                        wstrb_nxt = d_wstrb;
                    end else begin
                        we_nxt    = 1'b0;
                        addr_nxt  = i_addr;
                        wdata_nxt = '0;
                        wstrb_nxt = '0;
                    end
                end
            end
            BUSY: begin
                if (mem_ready || expire) begin
                    // mem_ready beats a coincident expiry
                    abort_nxt = !mem_ready;
                    if (owner_d) begin
                        d_ready_nxt = 1'b1;
                        d_rdata_nxt = mem_ready ? mem_rdata : '0;
                        d_error_nxt = mem_ready ? mem_error : 1'b1;
                    end else begin
                        i_ready_nxt = 1'b1;
                        i_rdata_nxt = mem_ready ? mem_rdata : '0;
                        i_error_nxt = mem_ready ? mem_error : 1'b1;
                    end
                end else if (timer != '1) begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Registered datapath and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_d   <= 1'b0;
            timer     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            i_ready   <= 1'b0;
            i_rdata   <= '0;
            i_error   <= 1'b0;
            d_ready   <= 1'b0;
            d_rdata   <= '0;
            d_error   <= 1'b0;
            mem_abort <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d    <= 1'b0;
`endif
        end else begin
            owner_d   <= owner_d_nxt;
            timer     <= timer_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            mem_wstrb <= wstrb_nxt;
            i_ready   <= i_ready_nxt;
            i_rdata   <= i_rdata_nxt;
            i_error   <= i_error_nxt;
            d_ready   <= d_ready_nxt;
            d_rdata   <= d_rdata_nxt;
            d_error   <= d_error_nxt;
            mem_abort <= abort_nxt;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d    <= last_d_nxt;
`endif
        end
    end

endmodule
